// File: rtl/uart_tx_engine.sv
// uart_tx_engine: TX FIFO and serializer for the UART transmit path.
// Bytes pushed from the THR are buffered in a circular FIFO and sent
// LSB first using the frame format latched from LCR when each byte is popped.
module uart_tx_engine #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_COUNTER_W = 5,
  parameter int TICKS_PER_BIT  = 16
) (
  input  logic                      clk,
  input  logic                      wb_rst_n,
  input  logic [7:0]                lcr,
  input  logic                      tf_push,
  input  logic [7:0]                wb_dat_i,
  input  logic                      enable,
  input  logic                      tx_reset,
  output logic                      stx_pad_o,
  output logic [2:0]                tstate,
  output logic [FIFO_COUNTER_W-1:0] tf_count,
  output logic                      tf_overrun
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TICK_W = $clog2(2 * TICKS_PER_BIT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t              state;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [7:0]          shift_q;
  logic [2:0]          bit_cnt;
  logic [2:0]          last_bit;
  logic [TICK_W-1:0]   tick_cnt;
  logic [TICK_W-1:0]   stop_len;
  logic [TICK_W-1:0]   tick_lim;
  logic                pe_q;
  logic                par_q;
  logic                pop;
  logic                full;
  logic                push_ok;
  logic                bit_end;
  logic                line_bit;
  logic [7:0]          head;
  logic [7:0]          data_mask;
  logic                par_raw;
  logic                par_next;
  logic [TICK_W-1:0]   stop_next;
  logic                unused_lcr;

  // Bit 7 of LCR (divisor latch access) has no meaning on the transmit path.
  assign unused_lcr = lcr[7];

  // A pop cancelled by tx_reset leaves the FIFO untouched and the FSM returns to IDLE.
  assign pop     = (state == POP) && (tf_count != '0) && !tx_reset;
  assign full    = (tf_count == FIFO_COUNTER_W'(FIFO_DEPTH));
  assign push_ok = tf_push && (!full || pop);
  assign head    = mem[rd_ptr];

  // Frame format evaluated against the FIFO head, captured only in POP.
  assign data_mask = 8'hFF >> (2'd3 - lcr[1:0]);
  assign par_raw   = ^(head & data_mask);
  assign par_next  = lcr[5] ? ~lcr[4] : (lcr[4] ? par_raw : ~par_raw);
  assign stop_next = !lcr[2]            ? TICK_W'(TICKS_PER_BIT) :
                     (lcr[1:0] == 2'd0) ? TICK_W'(TICKS_PER_BIT + TICKS_PER_BIT / 2) :
                                          TICK_W'(2 * TICKS_PER_BIT);

  // Stop bits use the latched stop length; every other bit is one bit time.
  assign tick_lim = (state == STOP) ? stop_len : TICK_W'(TICKS_PER_BIT);
  assign bit_end  = enable && ((tick_cnt + 1'b1) == tick_lim);
  assign tstate   = state;

  // Line level implied by the current serializer state.
  always_comb begin
    line_bit = 1'b1;
    case (state)
      START:   line_bit = 1'b0;
      DATA:    line_bit = shift_q[0];
      PARITY:  line_bit = par_q;
      default: line_bit = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (wb_rst_n && !tx_reset && push_ok) mem[wr_ptr] <= wb_dat_i;
  end

  // FIFO pointers, occupancy and the dropped-push pulse.
  always_ff @(posedge clk) begin
    if (!wb_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tf_count   <= '0;
      tf_overrun <= 1'b0;
    end else begin
      tf_overrun <= tf_push && full && !pop && !tx_reset;
      if (tx_reset) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        tf_count <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !pop)      tf_count <= tf_count + 1'b1;
        else if (pop && !push_ok) tf_count <= tf_count - 1'b1;
      end
    end
  end

  // Serializer FSM with registered line output; break masks the line without stalling.
  always_ff @(posedge clk) begin
    if (!wb_rst_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      last_bit  <= '0;
      tick_cnt  <= '0;
      stop_len  <= TICK_W'(TICKS_PER_BIT);
      pe_q      <= 1'b0;
      par_q     <= 1'b0;
      stx_pad_o <= 1'b1;
    end else begin
      stx_pad_o <= line_bit & ~lcr[6];
      if ((state inside {START, DATA, PARITY, STOP}) && enable)
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (tf_count != '0) state <= POP;
        end
        POP: begin
          if (pop) begin
            shift_q  <= head;
            last_bit <= {1'b1, lcr[1:0]};
            pe_q     <= lcr[3];
            par_q    <= par_next;
            stop_len <= stop_next;
            bit_cnt  <= '0;
            tick_cnt <= '0;
            state    <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (bit_end) state <= DATA;
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt == last_bit) state <= pe_q ? PARITY : STOP;
            else                     bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (bit_end) state <= (tf_count != '0) ? POP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: table-driven frame waveforms, FIFO corner sequences and
// randomized traffic decoded from the line against a frame-level model.
module tb_uart_tx_engine;
  localparam int FIFO_DEPTH     = 16;
  localparam int FIFO_COUNTER_W = 5;
  localparam int TICKS_PER_BIT  = 16;

  logic                      clk;
  logic                      wb_rst_n;
  logic [7:0]                lcr;
  logic                      tf_push;
  logic [7:0]                wb_dat_i;
  logic                      enable;
  logic                      tx_reset;
  logic                      stx_pad_o;
  logic [2:0]                tstate;
  logic [FIFO_COUNTER_W-1:0] tf_count;
  logic                      tf_overrun;

  uart_tx_engine #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .FIFO_COUNTER_W(FIFO_COUNTER_W),
    .TICKS_PER_BIT(TICKS_PER_BIT)
  ) dut (
    .clk(clk),
    .wb_rst_n(wb_rst_n),
    .lcr(lcr),
    .tf_push(tf_push),
    .wb_dat_i(wb_dat_i),
    .enable(enable),
    .tx_reset(tx_reset),
    .stx_pad_o(stx_pad_o),
    .tstate(tstate),
    .tf_count(tf_count),
    .tf_overrun(tf_overrun)
  );

  int         errors = 0;
  int         checks = 0;
  int         en_mode = 0;   // 0: enable low, 1: every clk, 2: random
  bit         cap_on = 0;
  bit         rx_ticks[$];
  bit         pat_q[$];
  logic [7:0] byte_q[$];
  logic       en_s;

  typedef struct {
    logic [7:0] lcr_v;
    logic [7:0] data;
    int         exp_par;   // -1: no parity bit
    int         exp_stop;  // stop length in ticks
  } vec_t;
  vec_t vecs[9];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    enable = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      enable = (en_mode == 1) || ((en_mode == 2) && ($urandom_range(0, 3) != 0));
    end
  end

  // The line value after an edge is the bit of the state that just consumed a tick.
  always @(posedge clk) begin
    en_s = enable;
    #1;
    if (cap_on && en_s) rx_ticks.push_back(stx_pad_o);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic push_byte(input logic [7:0] d);
    tf_push  = 1'b1;
    wb_dat_i = d;
    step();
    tf_push  = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!(tstate == 3'd0 && tf_count == '0) && n < 30000) begin
      step();
      n++;
    end
    if (n >= 30000) fail_now({tag, " empty"});
    repeat (3) step();
  endtask

  // Reference frame: tick-level line pattern from start bit through parity.
  task automatic build_frame(input logic [7:0] b, input logic [7:0] lv, output int stop_len);
    int n;
    int ones;
    bit p;
    n = 5 + int'(lv[1:0]);
    pat_q.delete();
    repeat (TICKS_PER_BIT) pat_q.push_back(1'b0);
    ones = 0;
    for (int k = 0; k < n; k++) begin
      repeat (TICKS_PER_BIT) pat_q.push_back(b[k]);
      ones += int'(b[k]);
    end
    if (lv[3]) begin
      if (lv[5])      p = ~lv[4];
      else if (lv[4]) p = (ones % 2) == 1;
      else            p = (ones % 2) == 0;
      repeat (TICKS_PER_BIT) pat_q.push_back(p);
    end
    if (!lv[2])      stop_len = TICKS_PER_BIT;
    else if (n == 5) stop_len = TICKS_PER_BIT + TICKS_PER_BIT / 2;
    else             stop_len = 2 * TICKS_PER_BIT;
  endtask

  // Walk the captured tick stream, matching each expected byte in order.
  task automatic check_stream(input logic [7:0] lv, input string tag);
    int i;
    int k;
    int stop_len;
    int nf;
    int zeros;
    bit ok;
    logic [7:0] b;
    i  = 0;
    nf = 0;
    while (byte_q.size() > 0) begin
      b = byte_q.pop_front();
      build_frame(b, lv, stop_len);
      while (i < rx_ticks.size() && rx_ticks[i] == 1'b1) i++;
      ok = (i + pat_q.size() <= rx_ticks.size());
      for (int j = 0; ok && j < pat_q.size(); j++)
        if (rx_ticks[i + j] != pat_q[j]) ok = 1'b0;
      i += pat_q.size();
      k = 0;
      while (i < rx_ticks.size() && rx_ticks[i] == 1'b1) begin
        k++;
        i++;
      end
      if (k < stop_len) ok = 1'b0;
      check($sformatf("%s frame%0d byte %02h", tag, nf, b), int'(ok), 1);
      nf++;
    end
    zeros = 0;
    for (int j = i; j < rx_ticks.size(); j++) if (!rx_ticks[j]) zeros++;
    check({tag, " extra frames"}, zeros, 0);
    rx_ticks.delete();
  endtask

  // Cycle-exact waveform with enable every clk; optional break window (on, off].
  task automatic run_frame(input int idx, input logic [7:0] lv, input logic [7:0] d,
                           input int exp_par, input int exp_stop,
                           input int brk_on, input int brk_off);
    bit   exp_w[$];
    int   n;
    int   len;
    int   t;
    int   bad_at;
    bit   e;
    logic [2:0] ts_pre;
    logic [2:0] ts_end;
    n = 5 + int'(lv[1:0]);
    repeat (TICKS_PER_BIT) exp_w.push_back(1'b0);
    for (int k = 0; k < n; k++) repeat (TICKS_PER_BIT) exp_w.push_back(d[k]);
    if (exp_par >= 0) repeat (TICKS_PER_BIT) exp_w.push_back(exp_par == 1);
    repeat (exp_stop) exp_w.push_back(1'b1);
    len = exp_w.size();
    lcr = lv;
    push_byte(d);
    t = 0;
    while (stx_pad_o !== 1'b0 && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) begin
      fail_now($sformatf("wave%0d start bit", idx));
      return;
    end
    bad_at = -1;
    ts_pre = '0;
    ts_end = '0;
    for (int j = 0; j < len; j++) begin
      e = exp_w[j];
      if (j > brk_on && j <= brk_off) e = 1'b0;
      if (stx_pad_o !== e && bad_at < 0) bad_at = j;
      if (j == len - 2) ts_pre = tstate;
      if (j == len - 1) ts_end = tstate;
      if (j == brk_on)  lcr = lv | 8'h40;
      if (j == brk_off) lcr = lv;
      if (j < len - 1) step();
    end
    check($sformatf("wave%0d first bad cycle", idx), bad_at, -1);
    check($sformatf("wave%0d tstate stop->idle", idx), int'({ts_pre, ts_end}), int'({3'd5, 3'd0}));
    step();
  endtask

  initial begin
    int n;
    logic [7:0] d;

    vecs[0] = '{8'h03, 8'hA5, -1, 16};
    vecs[1] = '{8'h1E, 8'h41,  0, 32};
    vecs[2] = '{8'h3A, 8'h01,  0, 16};
    vecs[3] = '{8'h04, 8'h1F, -1, 24};
    vecs[4] = '{8'h0B, 8'hA5,  1, 16};
    vecs[5] = '{8'h1A, 8'h07,  1, 16};
    vecs[6] = '{8'h2B, 8'h00,  1, 16};
    vecs[7] = '{8'h05, 8'h2A, -1, 32};
    vecs[8] = '{8'h0C, 8'h13,  0, 24};

    wb_rst_n = 1'b0;
    tf_push  = 1'b0;
    wb_dat_i = '0;
    tx_reset = 1'b0;
    lcr      = 8'h03;
    en_mode  = 1;
    repeat (3) step();
    check("reset outputs", int'({stx_pad_o, tstate, tf_count, tf_overrun}), int'(10'b1_000_00000_0));
    wb_rst_n = 1'b1;
    repeat (3) step();
    check("idle after reset", int'({stx_pad_o, tstate, tf_count, tf_overrun}), int'(10'b1_000_00000_0));

    for (int v = 0; v < 9; v++)
      run_frame(v, vecs[v].lcr_v, vecs[v].data, vecs[v].exp_par, vecs[v].exp_stop, -1, -1);

    run_frame(99, 8'h03, 8'hA5, -1, 16, 40, 70);

    // FIFO fill with the serializer stalled, then drain.
    en_mode = 0;
    repeat (2) step();
    lcr    = 8'h03;
    cap_on = 1'b1;
    for (int q = 0; q < 17; q++) begin
      d = 8'($urandom);
      byte_q.push_back(d);
      push_byte(d);
    end
    check("ovf count peak", int'(tf_count), 16);
    check("ovf quiet on 17th", int'(tf_overrun), 0);
    push_byte(8'h5A);
    check("ovf pulse", int'(tf_overrun), 1);
    check("ovf count held", int'(tf_count), 16);
    step();
    check("ovf pulse width", int'(tf_overrun), 0);
    repeat (50) step();
    check("stalled in start", int'(tstate), 2);
    en_mode = 1;
    wait_empty("ovf");
    cap_on = 1'b0;
    check_stream(8'h03, "ovf");

    // tx_reset while frame 1 is in DATA with three bytes queued.
    lcr    = 8'h03;
    cap_on = 1'b1;
    for (int q = 0; q < 4; q++) begin
      d = 8'($urandom);
      if (q == 0) byte_q.push_back(d);
      push_byte(d);
    end
    n = 0;
    while (tstate != 3'd3 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) fail_now("txr reach data");
    repeat (20) step();
    check("txr count before", int'(tf_count), 3);
    tx_reset = 1'b1;
    step();
    tx_reset = 1'b0;
    check("txr count cleared", int'(tf_count), 0);
    wait_empty("txr");
    repeat (200) step();
    check("txr stays idle", int'(tstate), 0);
    cap_on = 1'b0;
    check_stream(8'h03, "txr");

    // Randomized traffic with random enable density and line format.
    for (int bt = 0; bt < 4; bt++) begin
      logic [7:0] lv;
      int nb;
      lv      = 8'($urandom_range(0, 63));
      nb      = $urandom_range(1, 10);
      lcr     = lv;
      en_mode = 2;
      cap_on  = 1'b1;
      for (int q = 0; q < nb; q++) begin
        d = 8'($urandom);
        byte_q.push_back(d);
        push_byte(d);
        repeat ($urandom_range(0, 3)) step();
      end
      wait_empty($sformatf("rand%0d", bt));
      cap_on = 1'b0;
      check_stream(lv, $sformatf("rand%0d", bt));
    end

    // Synchronous reset in the middle of a frame with one byte still queued.
    en_mode = 1;
    lcr     = 8'h03;
    push_byte(8'h55);
    push_byte(8'h66);
    repeat (30) step();
    wb_rst_n = 1'b0;
    step();
    check("mid-frame reset", int'({stx_pad_o, tstate, tf_count, tf_overrun}), int'(10'b1_000_00000_0));
    wb_rst_n = 1'b1;
    repeat (20) step();
    check("after mid-frame reset", int'({stx_pad_o, tstate, tf_count, tf_overrun}), int'(10'b1_000_00000_0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
